cpu_mul_cell_pipe: RTL
======================

Name: cpu_mul_cell_pipe

Overview:
- Parametrised, pipelined integer multiplier cell for the soft-CPU execute/memory stages.
- Successor to the fixed 32-bit low-word multiplier cell.
- Generic DATA_W; decomposes the product into four half-width partial products.
- Supports low-word and signed/unsigned/mixed high-word results (mul, mulxss, mulxsu, mulxuu), with stall (ena), flush, per-stage valid tracking and optional output register.

Parameters:
- DATA_W, 32: operand and result width; must be even and >= 8. PART_W = DATA_W/2 is derived, not a parameter.
- OUT_REG, 1: 1 adds an output register stage (latency 3); 0 leaves the result combinational from stage 2 (latency 2).

Ports:
- clk, input, 1: clock, all state on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- ena, input, 1: pipeline advance; 0 freezes every stage register and valid bit.
- flush, input, 1: synchronous kill of all in-flight valid bits; takes effect only when ena=1.
- in_valid, input, 1: src1/src2/op carry a request this cycle.
- op, input, 2: 00 MUL (low word), 01 MULXSS, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXUU.
- src1, input, DATA_W: multiplicand.
- src2, input, DATA_W: multiplier.
- out_valid, output, 1: result holds a completed product.
- result, output, DATA_W: selected word of the 2*DATA_W product.
- busy, output, 1: OR of all in-flight valid bits, including out_valid.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage registers, valid bits, out_valid and busy = 0; result = 0. Reset mid-operation discards in-flight products with no partial output.
- Stage 1 (capture): on ena=1, register src1, src2, op and in_valid. Register the sign bits s1 = src1[MSB] & (op==01 | op==10) and s2 = src2[MSB] & (op==01).
- Stage 2 (partial products): on ena=1, register the four unsigned PART_W x PART_W products LL, LH, HL, HH (each 2*PART_W wide), plus op, s1, s2, and the masked corrections c1 = s1 ? src2 : 0 and c2 = s2 ? src1 : 0.
- Combine (after stage 2): unsigned P = LL + (LH<<PART_W) + (HL<<PART_W) + (HH<<DATA_W), computed in 2*DATA_W+2 bits. hi = P[2*DATA_W-1:DATA_W] - c1 - c2, modulo 2^DATA_W. lo = P[DATA_W-1:0].
- Result select: result = lo for op 00; hi otherwise.
- OUT_REG=1: combine output registered on ena=1 (latency 3). OUT_REG=0: result/out_valid driven combinationally from stage-2 registers (latency 2).
- Latency is measured in ena=1 cycles, from in_valid sampled to out_valid=1.
- Throughput: one request per ena=1 cycle; back-to-back accepted with no bubbles.
- ena=0: no register changes. result and out_valid hold; a request presented with in_valid=1 is not captured, and the caller must hold it.
- flush with ena=1: all valid bits cleared. The current-cycle in_valid is also dropped. Data registers may load but are don't-care. flush with ena=0 has no effect.
- When out_valid=0, result is unspecified but must not be X after reset.
- All arithmetic wraps modulo 2^DATA_W; no overflow flag.

Decomposition:
- Shared package cpu_mul_pkg:
  - op encoding constants MUL_OP_LO, MUL_OP_XSS, MUL_OP_XSU, MUL_OP_XUU;
  - a stage payload typedef (op, sign flags, valid);
  - a function giving latency from OUT_REG.
- One sub-module: cpu_mul_part, a registered unsigned PART_W x PART_W multiplier with ena and async clear. It is instantiated four times so synthesis maps each to a DSP block.

Test Plan:
- DATA_W=32, OUT_REG=1: src1=src2=0xFFFFFFFF, ops 00/01/10/11 back-to-back -> results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on four consecutive cycles, first out_valid 3 cycles after the first in_valid.
- src1=src2=0x80000000 with op 01 and op 11 -> 0x40000000 both; op 00 -> 0x00000000. src1=src2=0x00010000 with op 11 -> 0x00000001.
- Stall: issue one request, drop ena for 5 cycles after the first edge -> out_valid rises exactly 3 ena=1 edges after capture; result is stable while ena=0.
- Flush: three requests in flight, then flush=1 with ena=1 -> out_valid and busy = 0 next cycle; the next request completes normally with the correct value.
- Reset: assert reset_n=0 asynchronously mid-pipeline -> out_valid, busy and result = 0 immediately, with no spurious out_valid after release.
- Randomised 10k ops at DATA_W=32 and DATA_W=16, each with OUT_REG 0 and 1, against a 2*DATA_W-wide signed/unsigned reference model -> zero mismatches; latency 2 or 3 per OUT_REG.

Source files
------------

// File: rtl/cpu_mul_pkg.sv
// Shared definitions for the pipelined multiplier cell: op encodings,
// the per-stage control payload and the configuration-dependent latency.
package cpu_mul_pkg;

  localparam logic [1:0] MUL_OP_LO  = 2'b00;
  localparam logic [1:0] MUL_OP_XSS = 2'b01;
  localparam logic [1:0] MUL_OP_XSU = 2'b10;
  localparam logic [1:0] MUL_OP_XUU = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       s1;
    logic       s2;
    logic       vld;
  } mul_stage_t;

  function automatic int unsigned mul_latency(input bit out_reg);
    return out_reg ? 32'd3 : 32'd2;
  endfunction

endpackage

// File: rtl/cpu_mul_part.sv
// Registered unsigned PART_W x PART_W multiplier; one instance per partial
// product so each maps onto its own DSP block.
module cpu_mul_part #(
  parameter int PART_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_ena,
  input  logic [PART_W-1:0]     i_a,
  input  logic [PART_W-1:0]     i_b,
  output logic [2*PART_W-1:0]   o_p
);

  logic [2*PART_W-1:0] r_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= '0;
    end else if (i_ena) begin
      r_p <= {{PART_W{1'b0}}, i_a} * {{PART_W{1'b0}}, i_b};
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/cpu_mul_cell_pipe.sv
// Pipelined integer multiplier cell: low word or signed/unsigned/mixed high
// word of src1*src2, built from four half-width unsigned partial products.
import cpu_mul_pkg::*;

module cpu_mul_cell_pipe #(
  parameter int DATA_W  = 32,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int PART_W = DATA_W / 2;

  mul_stage_t        w_pl_p0, r_pl_p1, r_pl_p2;
  logic [DATA_W-1:0] r_src1_p1, r_src2_p1;
  logic [DATA_W-1:0] r_c1_p2, r_c2_p2;
  logic [DATA_W-1:0] w_ll_p2, w_lh_p2, w_hl_p2, w_hh_p2;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_lo, w_hi, w_res;

  always_comb begin
    w_pl_p0.op  = op;
    w_pl_p0.s1  = src1[DATA_W-1] & ((op == MUL_OP_XSS) | (op == MUL_OP_XSU));
    w_pl_p0.s2  = src2[DATA_W-1] & (op == MUL_OP_XSS);
    w_pl_p0.vld = in_valid & ~flush;
  end

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pl_p1   <= '0;
      r_src1_p1 <= '0;
      r_src2_p1 <= '0;
    end else if (ena) begin
      r_pl_p1   <= w_pl_p0;
      r_src1_p1 <= src1;
      r_src2_p1 <= src2;
    end
  end

  // Stage 2: unsigned partial products and signed-correction terms
  cpu_mul_part #(.PART_W(PART_W)) u_part_ll (
    .clk(clk), .reset_n(reset_n), .i_ena(ena),
    .i_a(r_src1_p1[PART_W-1:0]), .i_b(r_src2_p1[PART_W-1:0]), .o_p(w_ll_p2));
  cpu_mul_part #(.PART_W(PART_W)) u_part_lh (
    .clk(clk), .reset_n(reset_n), .i_ena(ena),
    .i_a(r_src1_p1[PART_W-1:0]), .i_b(r_src2_p1[DATA_W-1:PART_W]), .o_p(w_lh_p2));
  cpu_mul_part #(.PART_W(PART_W)) u_part_hl (
    .clk(clk), .reset_n(reset_n), .i_ena(ena),
    .i_a(r_src1_p1[DATA_W-1:PART_W]), .i_b(r_src2_p1[PART_W-1:0]), .o_p(w_hl_p2));
  cpu_mul_part #(.PART_W(PART_W)) u_part_hh (
    .clk(clk), .reset_n(reset_n), .i_ena(ena),
    .i_a(r_src1_p1[DATA_W-1:PART_W]), .i_b(r_src2_p1[DATA_W-1:PART_W]), .o_p(w_hh_p2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pl_p2 <= '0;
      r_c1_p2 <= '0;
      r_c2_p2 <= '0;
    end else if (ena) begin
      r_pl_p2 <= '{op: r_pl_p1.op, s1: r_pl_p1.s1, s2: r_pl_p1.s2,
                   vld: r_pl_p1.vld & ~flush};
      r_c1_p2 <= r_pl_p1.s1 ? r_src2_p1 : '0;
      r_c2_p2 <= r_pl_p1.s2 ? r_src1_p1 : '0;
    end
  end

  // Combine: the exact unsigned product always fits in 2*DATA_W bits, and every
  // partial sum is bounded by it, so no guard bits are needed above the product.
  always_comb begin
    w_prod = {{DATA_W{1'b0}}, w_ll_p2}
           + ({{DATA_W{1'b0}}, w_lh_p2} << PART_W)
           + ({{DATA_W{1'b0}}, w_hl_p2} << PART_W)
           + {w_hh_p2, {DATA_W{1'b0}}};
    w_lo   = w_prod[DATA_W-1:0];
    w_hi   = w_prod[2*DATA_W-1:DATA_W]
           - (r_pl_p2.s1 ? r_c1_p2 : '0)
           - (r_pl_p2.s2 ? r_c2_p2 : '0);
    w_res  = (r_pl_p2.op == MUL_OP_LO) ? w_lo : w_hi;
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic              r_vld_p3;
      logic [DATA_W-1:0] r_res_p3;

      // Stage 3: optional output register
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_vld_p3 <= 1'b0;
          r_res_p3 <= '0;
        end else if (ena) begin
          r_vld_p3 <= r_pl_p2.vld & ~flush;
          r_res_p3 <= w_res;
        end
      end

      assign out_valid = r_vld_p3;
      assign result    = r_res_p3;
      assign busy      = r_pl_p1.vld | r_pl_p2.vld | r_vld_p3;
    end else begin : g_out_comb
      assign out_valid = r_pl_p2.vld;
      assign result    = w_res;
      assign busy      = r_pl_p1.vld | r_pl_p2.vld;
    end
  endgenerate

endmodule
